rv32m_muldiv_sequencer: RTL



---
 rtl/rv32m_pkg.sv | 36 +++
 rtl/rv32m_muldiv_sequencer_step.sv | 41 ++++
 rtl/rv32m_muldiv_sequencer.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/rv32m_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rv32m_pkg
// Brief    : Shared constants, FUNCT3 codes and FSM encoding for the RV32M
//            multiply/divide sequencer.
// Revision : 1.0
// ============================================================================
package rv32m_pkg;

   localparam int XLEN  = 32;
   localparam int CNT_W = 5;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam logic [XLEN-1:0] DIV0_QUOT = 32'hFFFF_FFFF;

   function automatic logic [XLEN-1:0] cond_negate(input logic [XLEN-1:0] v, input logic neg);
      return neg ? (~v + 1'b1) : v;
   endfunction

endpackage
`default_nettype wire

// File: rtl/rv32m_muldiv_sequencer_step.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_iter_step
// Brief    : One combinational radix-2 iteration: shift-add multiply
//            (i_mode=0) or restoring divide step (i_mode=1) on {hi, lo}.
// Revision : 1.0
// ============================================================================
module muldiv_iter_step
   import rv32m_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            i_mode,
   input  logic [XLEN-1:0] i_hi,
   input  logic [XLEN-1:0] i_lo,
   input  logic [XLEN-1:0] i_opnd,
   output logic [XLEN-1:0] o_hi,
   output logic [XLEN-1:0] o_lo
);

   logic [XLEN:0]   w_sum;
   logic [XLEN:0]   w_shift;
   logic            w_ge;
   logic [XLEN-1:0] w_diff;

   always_comb begin
      w_sum   = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_opnd} : '0);
      w_shift = {i_hi, i_lo[XLEN-1]};
      w_ge    = (w_shift >= {1'b0, i_opnd});
      // When the trial subtraction succeeds the difference is below the divisor, so XLEN bits suffice
      w_diff  = w_shift[XLEN-1:0] - i_opnd;
      o_hi    = w_sum[XLEN:1];
      o_lo    = {w_sum[0], i_lo[XLEN-1:1]};
      if (i_mode) begin
         o_hi = w_ge ? w_diff : w_shift[XLEN-1:0];
         o_lo = {i_lo[XLEN-2:0], w_ge};
      end
   end

endmodule
`default_nettype wire

// File: rtl/rv32m_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : rv32m_muldiv_sequencer
// Brief    : Multi-cycle RV32M MUL/DIV/REM sequencer with pipeline stall,
//            one-cycle DONE strobe and divide-by-zero/overflow fast path.
// Revision : 1.0
// ============================================================================
module rv32m_muldiv_sequencer #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 5
) (
   input  logic            CLK,
   input  logic            RESET,
   input  logic            START,
   input  logic [2:0]      FUNCT3,
   input  logic [XLEN-1:0] OPERAND1,
   input  logic [XLEN-1:0] OPERAND2,
   input  logic            FLUSH,
   output logic            STALL,
   output logic            BUSY,
   output logic            DONE,
   output logic [XLEN-1:0] RESULT
);
   import rv32m_pkg::*;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [CNT_W-1:0]  r_cnt;
   logic [2:0]        r_f3;
   logic [XLEN-1:0]   r_hi;
   logic [XLEN-1:0]   r_lo;
   logic [XLEN-1:0]   r_opnd;
   logic [XLEN-1:0]   r_result;
   logic              r_neg;
   logic              r_busy;

   logic              w_start;
   logic              w_is_div;
   logic              w_is_rem;
   logic              w_sgn1;
   logic              w_sgn2;
   logic              w_neg;
   logic              w_div0;
   logic              w_ovf;
   logic              w_fast;
   logic [XLEN-1:0]   w_fast_res;
   logic [XLEN-1:0]   w_mag1;
   logic [XLEN-1:0]   w_mag2;
   logic [XLEN-1:0]   w_hi_nxt;
   logic [XLEN-1:0]   w_lo_nxt;
   logic [2*XLEN-1:0] w_prod_fix;
   logic [XLEN-1:0]   w_fix_res;

   // Start-time decode of the incoming request
   always_comb begin
      w_start    = START & ~FLUSH;
      w_is_div   = FUNCT3[2];
      w_is_rem   = FUNCT3[2] & FUNCT3[1];
      w_sgn1     = OPERAND1[XLEN-1] & (FUNCT3 != F3_MULHU) & (FUNCT3 != F3_DIVU) & (FUNCT3 != F3_REMU);
      w_sgn2     = OPERAND2[XLEN-1] & ((FUNCT3 == F3_MUL) | (FUNCT3 == F3_MULH) |
                                       (FUNCT3 == F3_DIV) | (FUNCT3 == F3_REM));
      w_neg      = w_is_rem ? w_sgn1 : (w_sgn1 ^ w_sgn2);
      w_mag1     = cond_negate(OPERAND1, w_sgn1);
      w_mag2     = cond_negate(OPERAND2, w_sgn2);
      w_div0     = w_is_div & (OPERAND2 == '0);
      w_ovf      = ((FUNCT3 == F3_DIV) | (FUNCT3 == F3_REM)) &
                   (OPERAND1 == {1'b1, {(XLEN-1){1'b0}}}) & (OPERAND2 == '1);
      w_fast     = w_div0 | w_ovf;
      if (w_div0)
         w_fast_res = w_is_rem ? OPERAND1 : DIV0_QUOT;
      else
         w_fast_res = w_is_rem ? '0 : OPERAND1;
   end

   muldiv_iter_step #(
      .XLEN (XLEN)
   ) u_step (
      .i_mode (r_f3[2]),
      .i_hi   (r_hi),
      .i_lo   (r_lo),
      .i_opnd (r_opnd),
      .o_hi   (w_hi_nxt),
      .o_lo   (w_lo_nxt)
   );

   // Sign correction and output selection for the FIX cycle
   always_comb begin
      w_prod_fix = r_neg ? (~{r_hi, r_lo} + 1'b1) : {r_hi, r_lo};
      case (r_f3)
         F3_MUL:            w_fix_res = w_prod_fix[XLEN-1:0];
         F3_MULH,
         F3_MULHSU,
         F3_MULHU:          w_fix_res = w_prod_fix[2*XLEN-1:XLEN];
         F3_DIV, F3_DIVU:   w_fix_res = cond_negate(r_lo, r_neg);
         default:           w_fix_res = cond_negate(r_hi, r_neg);
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state <= S_IDLE;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_busy  <= (w_state_nxt == S_CALC) | (w_state_nxt == S_FIX);
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      STALL       = 1'b0;
      DONE        = 1'b0;
      case (r_state)
         S_IDLE: begin
            STALL = w_start;
            if (w_start)
               w_state_nxt = w_fast ? S_DONE : S_CALC;
         end
         S_CALC: begin
            STALL = 1'b1;
            if (FLUSH)
               w_state_nxt = S_IDLE;
            else if (r_cnt == '1)
               w_state_nxt = S_FIX;
         end
         S_FIX: begin
            STALL       = 1'b1;
            w_state_nxt = FLUSH ? S_IDLE : S_DONE;
         end
         default: begin
            DONE        = 1'b1;
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_cnt    <= '0;
         r_f3     <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_opnd   <= '0;
         r_neg    <= 1'b0;
         r_result <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_start) begin
                  r_f3  <= FUNCT3;
                  r_neg <= w_neg;
                  r_cnt <= '0;
                  r_hi  <= '0;
                  if (w_fast) begin
                     r_result <= w_fast_res;
                  end else begin
                     // Multiply iterates on the multiplier; divide shifts the dividend out of lo
                     r_lo   <= w_is_div ? w_mag1 : w_mag2;
                     r_opnd <= w_is_div ? w_mag2 : w_mag1;
                  end
               end
            end
            S_CALC: begin
               r_hi  <= w_hi_nxt;
               r_lo  <= w_lo_nxt;
               r_cnt <= r_cnt + 1'b1;
            end
            S_FIX: begin
               if (!FLUSH)
                  r_result <= w_fix_res;
            end
            default: ;
         endcase
      end
   end

   assign BUSY   = r_busy;
   assign RESULT = r_result;

endmodule
`default_nettype wire
